// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead pipeline: default width, group size
// and the group count derived from them.
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_GROUP = 4;

  function automatic int n_groups(input int width, input int group);
    return width / group;
  endfunction

  localparam int NGROUPS = n_groups(CLA_WIDTH, CLA_GROUP);

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit lookahead cell: group propagate/generate plus the carry
// into each bit of the group for a given carry-in.
module cla_group4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic       pg,
  output logic       gg,
  output logic [3:0] c
);

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_carry_pipe.sv
// Two-stage carry-lookahead adder back end: S1 registers per-group P/G and the
// group-local generate carries, S2 resolves group and bit carries and the sum.
module cla_carry_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NG = n_groups(WIDTH, GROUP);

  // Handshake: a transfer happens on a cycle where valid && ready. Each stage
  // advances when the stage after it is empty or being drained this cycle.
  logic s1_valid;
  logic s1_advance;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [WIDTH-1:0] loc_c;

  // Carry-in tied low: loc_c holds only the carries generated inside a group.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .p  (p[k*GROUP +: 4]),
      .g  (g[k*GROUP +: 4]),
      .ci (1'b0),
      .pg (grp_p[k]),
      .gg (grp_g[k]),
      .c  (loc_c[k*GROUP +: 4])
    );
  end

  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_lc;
  logic [NG-1:0]    s1_pg;
  logic [NG-1:0]    s1_gg;
  logic             s1_cin;

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_p   <= p;
      s1_lc  <= loc_c;
      s1_pg  <= grp_p;
      s1_gg  <= grp_g;
      s1_cin <= cin;
    end
  end

  logic [NG:0]    gc;
  logic [WIDTH:0] c;
  logic           term;
  logic           pp;

  // Group carries as flat sum-of-products so no carry ripples group to group.
  always_comb begin
    gc   = '0;
    c    = '0;
    term = 1'b0;
    pp   = 1'b0;
    gc[0] = s1_cin;
    for (int k = 1; k <= NG; k++) begin
      term = s1_cin;
      for (int m = 0; m < k; m++) term = term & s1_pg[m];
      gc[k] = term;
      for (int j = 0; j < k; j++) begin
        term = s1_gg[j];
        for (int m = j + 1; m < k; m++) term = term & s1_pg[m];
        gc[k] = gc[k] | term;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      pp = 1'b1;
      for (int m = (i / GROUP) * GROUP; m < i; m++) pp = pp & s1_p[m];
      c[i] = s1_lc[i] | (pp & gc[i / GROUP]);
    end
    c[WIDTH] = gc[NG];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_advance) out_valid <= s1_valid;
      if (s1_advance && s1_valid) begin
        sum  <= s1_p ^ c[WIDTH-1:0];
        cout <= c[WIDTH];
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

endmodule

// File: doc/cla_carry_pipe.md
CLA_CARRY_PIPE -- requirements
Module: cla_carry_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL have parameter GROUP, default 4, meaning bits per lookahead group; fixed at 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port p, input, WIDTH, per-bit propagate (x^y) from the half-adder cell array.
REQ-006 SHALL have port g, input, WIDTH, per-bit generate (x&y) from the half-adder cell array.
REQ-007 SHALL have port cin, input, 1, carry into bit 0.
REQ-008 SHALL have port in_valid, input, 1, meaning p/g/cin are valid this cycle.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts the input this cycle.
REQ-010 SHALL have port sum, output, WIDTH, the sum bits.
REQ-011 SHALL have port cout, output, 1, carry out of bit WIDTH-1.
REQ-012 SHALL have port ovf, output, 1, two's-complement overflow (c[WIDTH] ^ c[WIDTH-1]).
REQ-013 SHALL have port out_valid, output, 1, meaning sum/cout/ovf are valid.
REQ-014 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.

Function
REQ-015 SHALL accept an input transfer on a cycle where in_valid && in_ready; SHALL produce an output transfer on a cycle where out_valid && out_ready.
REQ-016 SHALL be a two-stage pipeline: S1 registers p, cin and group PG (Pg=&p[grp], Gg=lookahead OR of g/p within the group) per group; S2 computes group carries, then bit carries c[i], and registers sum=p^c[WIDTH-1:0], cout=c[WIDTH], ovf.
REQ-017 SHALL assert out_valid exactly 2 cycles after an accepted input when out_ready is held high; throughput is one result per cycle.
REQ-018 SHALL compute carries with lookahead only (group-level and bit-level), with no bit-serial ripple across groups.
REQ-019 SHALL drive in_ready = !s1_valid || s1_advance, where s1_advance = !out_valid || out_ready.
REQ-020 SHALL hold sum, cout, ovf and out_valid stable while out_valid && !out_ready; it SHALL NOT drop or duplicate any result.
REQ-021 SHALL accept a new input and drain the output in the same cycle when both stages are full and out_ready=1.
REQ-022 SHALL ignore p/g/cin when in_valid=0; on idle cycles out_valid SHALL fall after the last result is taken.
REQ-023 SHALL wrap modulo 2^WIDTH; all-propagate with cin=1 SHALL yield sum=0 and cout=1.
REQ-024 SHALL give results that are independent of the values the inputs take while in_ready=0.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear the S1 and S2 valid bits, sum, cout and ovf to 0; in_ready reads 1 in the first cycle after reset.
REQ-026 SHALL discard in-flight data when reset is asserted mid-operation; no stale result appears after reset.

Structure
REQ-027 SHALL take its WIDTH/GROUP defaults and the group count constant NGROUPS=WIDTH/GROUP from shared package cla_pkg.
REQ-028 SHALL instantiate sub-module cla_group4 (4-bit PG to group P/G plus internal carries) once per group; it is purely combinational.

Verification
REQ-029 SHALL be covered by the directed case p=0x5115, g=0x0220, cin=0 (0x1234+0x4321) -> sum=0x5555, cout=0, ovf=0, two cycles later.
REQ-030 SHALL be covered by the directed case p=0xFFFE, g=0x0001, cin=0 (0xFFFF+1) -> sum=0x0000, cout=1, ovf=0; and p=0xFFFF, g=0, cin=1 -> sum=0x0000, cout=1.
REQ-031 SHALL be covered by the directed case p=0x7FFE, g=0x0001, cin=0 (0x7FFF+1) -> sum=0x8000, cout=0, ovf=1.
REQ-032 SHALL be covered by the directed case of back-to-back inputs with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted inputs, first result held stable, then both results in order once out_ready=1.
REQ-033 SHALL be covered by the directed case of rst_n=0 for one cycle with 2 results in flight -> out_valid=0, sum=0 the next cycle, and no stale output afterwards.
REQ-034 SHALL be covered by a random stream with random out_ready, checked against a+b+cin from a scoreboard with an in-order exact match.
